out_hold: RTL and testbench

- Output-side counterpart to the input debouncer: conditions an internal request into a clean external drive line, e.g. a PTT, T/R relay or LED.
- Enforces an assert delay, a minimum high time and a minimum low time, all counted in the shared 1 ms strobe (msec_pulse).
- Sits between control logic and the output pad register. Protects relays and external gear from chatter and short pulses.

---
 rtl/out_hold.sv | 113 +++++++++++
 tb/tb_out_hold.sv | 130 +++++++++++++
 2 files changed

// File: rtl/out_hold.sv
// Output conditioner: turns an internal request into a clean external drive line
// with an assert delay and minimum high/low times counted in msec_pulse ticks.
module out_hold #(
  parameter int ON_DELAY = 2,
  parameter int MIN_HIGH = 6,
  parameter int MIN_LOW  = 6,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic msec_pulse,
  input  logic req,
  input  logic force_off,
  output logic out_pin,
  output logic busy
);

  localparam logic [2:0] S_LOW       = 3'd0;
  localparam logic [2:0] S_DELAY_ON  = 3'd1;
  localparam logic [2:0] S_HIGH_HOLD = 3'd2;
  localparam logic [2:0] S_HIGH      = 3'd3;
  localparam logic [2:0] S_LOW_HOLD  = 3'd4;

  localparam logic [CW-1:0] CNT_ON   = CW'(ON_DELAY);
  localparam logic [CW-1:0] CNT_HIGH = CW'(MIN_HIGH);
  localparam logic [CW-1:0] CNT_LOW  = CW'(MIN_LOW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          expire;

  // The entry edge only loads cnt, so a tick coincident with entry is not counted.
  assign expire = msec_pulse && (cnt == CNT_ONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_LOW: begin
        if (req && !force_off) begin
          if (ON_DELAY > 0) begin
            state_nxt = S_DELAY_ON;
            cnt_nxt   = CNT_ON;
          end else begin
            state_nxt = S_HIGH_HOLD;
            cnt_nxt   = CNT_HIGH;
          end
        end
      end
      S_DELAY_ON: begin
        if (!req || force_off) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (expire) begin
          state_nxt = S_HIGH_HOLD;
          cnt_nxt   = CNT_HIGH;
        end else if (msec_pulse) begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_HIGH_HOLD: begin
        if (force_off || (expire && !req)) begin
          state_nxt = S_LOW_HOLD;
          cnt_nxt   = CNT_LOW;
        end else if (expire) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (msec_pulse) begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!req || force_off) begin
          state_nxt = S_LOW_HOLD;
          cnt_nxt   = CNT_LOW;
        end
      end
      S_LOW_HOLD: begin
        // A request seen at expiry is picked up from LOW on the following edge.
        if (expire) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (msec_pulse) begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so no input reaches out_pin combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOW;
      cnt     <= '0;
      out_pin <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      out_pin <= (state_nxt == S_HIGH_HOLD) || (state_nxt == S_HIGH);
      busy    <= (state_nxt == S_DELAY_ON) || (state_nxt == S_HIGH_HOLD) ||
                 (state_nxt == S_LOW_HOLD);
    end
  end

endmodule

// File: tb/tb_out_hold.sv
// Directed bench for out_hold: ON_DELAY=2/MIN_HIGH=3/MIN_LOW=3 instance plus an
// ON_DELAY=0 instance, msec_pulse every 10 clks at relative phase 0.
module tb_out_hold;

  logic clk = 1'b0;
  logic rst;
  logic msec_pulse;
  logic req0;
  logic req1;
  logic force_off;
  logic out0;
  logic busy0;
  logic out1;
  logic busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  out_hold #(.ON_DELAY(2), .MIN_HIGH(3), .MIN_LOW(3), .CW(4)) dut0 (
    .clk(clk), .rst(rst), .msec_pulse(msec_pulse), .req(req0),
    .force_off(force_off), .out_pin(out0), .busy(busy0)
  );

  out_hold #(.ON_DELAY(0), .MIN_HIGH(3), .MIN_LOW(3), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .msec_pulse(msec_pulse), .req(req1),
    .force_off(force_off), .out_pin(out1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Drive the values sampled at relative edge t, then settle just after that edge.
  task automatic step(input int t, input logic r0, input logic r1,
                      input logic f, input logic rs);
    req0       = r0;
    req1       = r1;
    force_off  = f;
    rst        = rs;
    msec_pulse = (t % 10 == 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int t = 0; t < 3; t++) step(t, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst out0", out0, 1'b0);
    chk("rst busy0", busy0, 1'b0);
    chk("rst out1", out1, 1'b0);
    chk("rst busy1", busy1, 1'b0);

    // Basic cycle; LOW_HOLD entered on a pulse edge does not count that pulse
    for (int t = 0; t < 140; t++) begin
      step(t, t >= 6 && t < 100, 1'b0, 1'b0, 1'b0);
      chk($sformatf("basic out t=%0d", t), out0, t >= 20 && t < 100);
      chk($sformatf("basic busy t=%0d", t), busy0,
          (t >= 6 && t < 50) || (t >= 100 && t < 130));
    end

    // Short glitch aborts DELAY_ON
    for (int t = 0; t < 30; t++) begin
      step(t, t >= 6 && t < 13, 1'b0, 1'b0, 1'b0);
      chk($sformatf("glitch out t=%0d", t), out0, 1'b0);
      chk($sformatf("glitch busy t=%0d", t), busy0, t >= 6 && t < 13);
    end

    // Minimum high time
    for (int t = 0; t < 90; t++) begin
      step(t, t >= 6 && t < 26, 1'b0, 1'b0, 1'b0);
      chk($sformatf("minhi out t=%0d", t), out0, t >= 20 && t < 50);
      chk($sformatf("minhi busy t=%0d", t), busy0, t >= 6 && t < 80);
    end

    // Minimum low time with a 1-clk request dip
    for (int t = 0; t < 180; t++) begin
      step(t, t >= 6 && t != 55 && t < 140, 1'b0, 1'b0, 1'b0);
      chk($sformatf("minlo out t=%0d", t), out0,
          (t >= 20 && t < 55) || (t >= 100 && t < 140));
      chk($sformatf("minlo busy t=%0d", t), busy0,
          (t >= 6 && t < 50) || (t >= 55 && t < 80) ||
          (t >= 81 && t < 130) || (t >= 140 && t < 170));
    end

    // force_off mid-HIGH_HOLD, request held high through LOW_HOLD
    for (int t = 0; t < 160; t++) begin
      step(t, t >= 6 && t < 120, 1'b0, t == 35, 1'b0);
      chk($sformatf("force out t=%0d", t), out0,
          (t >= 20 && t < 35) || (t >= 80 && t < 120));
      chk($sformatf("force busy t=%0d", t), busy0,
          (t >= 6 && t < 60) || (t >= 61 && t < 110) || (t >= 120 && t < 150));
    end

    // Reset while high, then expiry with req low goes straight to LOW_HOLD
    for (int t = 0; t < 110; t++) begin
      step(t, t >= 6 && t < 45, 1'b0, 1'b0, t == 25);
      chk($sformatf("rst out t=%0d", t), out0,
          (t >= 20 && t < 25) || (t >= 40 && t < 70));
      chk($sformatf("rst busy t=%0d", t), busy0,
          (t >= 6 && t < 25) || (t >= 26 && t < 100));
    end

    // force_off aborts DELAY_ON and cuts HIGH
    for (int t = 0; t < 100; t++) begin
      step(t, t >= 6 && t < 66, 1'b0, t == 12 || t == 65, 1'b0);
      chk($sformatf("kill out t=%0d", t), out0, t >= 30 && t < 65);
      chk($sformatf("kill busy t=%0d", t), busy0,
          (t >= 6 && t < 12) || (t >= 13 && t < 60) || (t >= 65 && t < 90));
    end

    // Request lands on a pulse edge; ON_DELAY=0 instance asserts on the same edge
    for (int t = 0; t < 100; t++) begin
      step(t, t >= 10 && t < 60, t >= 10 && t < 60, 1'b0, 1'b0);
      chk($sformatf("edge out0 t=%0d", t), out0, t >= 30 && t < 60);
      chk($sformatf("edge busy0 t=%0d", t), busy0, t >= 10 && t < 90);
      chk($sformatf("nodly out1 t=%0d", t), out1, t >= 10 && t < 60);
      chk($sformatf("nodly busy1 t=%0d", t), busy1,
          (t >= 10 && t < 40) || (t >= 60 && t < 90));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
